// File: rtl/axi4lite_reg_pkg.sv
// axi4lite_reg_pkg: shared constants, register index decode and write FSM
// states for the AXI4-Lite scratch register slave.
package axi4lite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word slots of the register map; ID is the read-only identification word.
  typedef enum logic [2:0] {
    REG0 = 3'd0,
    REG1 = 3'd1,
    REG2 = 3'd2,
    REG3 = 3'd3,
    ID   = 3'd4
  } reg_idx_e;

  typedef struct packed {
    reg_idx_e idx;
    logic     invalid;
  } addr_dec_t;

  // Write channel progress: which halves of a write are held, or response pending.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } wr_state_e;

  // Decodes byte address bits [5:2]; anything past the ID word is unmapped.
  function automatic addr_dec_t addr_to_idx(input logic [3:0] word_addr);
    addr_dec_t dec;
    dec.idx     = REG0;
    dec.invalid = 1'b0;
    case (word_addr)
      4'd0:    dec.idx = REG0;
      4'd1:    dec.idx = REG1;
      4'd2:    dec.idx = REG2;
      4'd3:    dec.idx = REG3;
      4'd4:    dec.idx = ID;
      default: dec.invalid = 1'b1;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/axi4lite_reg_slave.sv
// axi4lite_reg_slave: AXI4-Lite slave with four read/write scratch registers
// and a read-only ID word. AW and W are held independently and committed
// together; reads return one beat per AR with registered data.
module axi4lite_reg_slave
  import axi4lite_reg_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] C_ID_VALUE         = 32'h7E57_0100
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [3:0][C_S_AXI_DATA_WIDTH-1:0]  reg_out
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic                                ready_en_q;
  wr_state_e                           state_q, state_d;
  logic [3:0]                          aw_word_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]       w_data_q;
  logic [STRB_W-1:0]                   w_strb_q;
  logic                                aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [3:0]                          wr_word;
  logic [C_S_AXI_DATA_WIDTH-1:0]       wr_data;
  logic [STRB_W-1:0]                   wr_strb;
  addr_dec_t                           wr_dec, rd_dec;
  logic [3:0][C_S_AXI_DATA_WIDTH-1:0]  regs_q;
  logic [1:0]                          bresp_q;
  logic                                rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [1:0]                          rresp_q, rresp_d;
  logic                                unused_ok;

  // Ready outputs depend only on registered state, never on an input valid.
  assign S_AXI_AWREADY = ready_en_q && (state_q == IDLE || state_q == HAVE_W);
  assign S_AXI_WREADY  = ready_en_q && (state_q == IDLE || state_q == HAVE_AW);
  assign S_AXI_BVALID  = (state_q == RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ready_en_q && !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_out       = regs_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A half that arrives in the commit cycle is taken straight from the bus.
  assign wr_word = (state_q == HAVE_AW) ? aw_word_q : S_AXI_AWADDR[5:2];
  assign wr_data = (state_q == HAVE_W)  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb = (state_q == HAVE_W)  ? w_strb_q  : S_AXI_WSTRB;
  assign wr_dec  = addr_to_idx(wr_word);
  assign wr_ok   = !wr_dec.invalid && (wr_dec.idx != ID);
  assign rd_dec  = addr_to_idx(S_AXI_ARADDR[5:2]);

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Hold all readies low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Write FSM next state; commit fires when the second half of a write lands.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          state_d = RESP;
        end else if (aw_hs) begin
          state_d = HAVE_AW;
        end else if (w_hs) begin
          state_d = HAVE_W;
        end
      end
      HAVE_AW: begin
        if (w_hs) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      HAVE_W: begin
        if (aw_hs) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (S_AXI_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding registers for whichever write half arrives first.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_word_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_word_q <= S_AXI_AWADDR[5:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Scratch registers take strobed byte lanes on a commit to a writable slot.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      regs_q <= '0;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs_q[wr_dec.idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write response code is latched alongside the commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)    bresp_q <= RESP_OKAY;
    else if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
  end

  // Read mux uses pre-commit register values, so a colliding read sees old data.
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    if (rd_dec.invalid) begin
      rresp_d = RESP_SLVERR;
    end else if (rd_dec.idx == ID) begin
      rdata_d = C_ID_VALUE;
    end else begin
      rdata_d = regs_q[rd_dec.idx[1:0]];
    end
  end

  // Read channel: capture on AR, hold the beat until the master takes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// tb_axi4lite_reg_slave: directed AXI4-Lite transactions against a
// transaction-level register model, checked every cycle on the falling edge.
module tb_axi4lite_reg_slave;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [5:0]        S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [5:0]        S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;
  logic [3:0][31:0]  reg_out;

  int n_checks = 0;
  int n_fail   = 0;

  axi4lite_reg_slave dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_out       (reg_out)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: register contents, pending write halves, and
  // queues of responses the slave still owes.
  logic [31:0] model_regs [4];
  logic        aw_have, w_have;
  logic [5:0]  m_aw_addr;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic        armed;

  function automatic logic [33:0] model_read(input logic [5:0] a);
    if (a < 6'h10)           return {2'b00, model_regs[a[3:2]]};
    else if (a[5:2] == 4'd4) return {2'b00, 32'h7E57_0100};
    else                     return {2'b10, 32'h0};
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < 6'h10) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_regs[a[3:2]][8*b +: 8] = d[8*b +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  // Readies are allowed only from the first clock edge after reset release.
  always @(posedge ACLK or negedge ARESETN) armed <= ARESETN;

  // Compare outputs to the model, then advance the model by this cycle's handshakes.
  always @(negedge ACLK) begin
    logic exp_awr, exp_wr, exp_arr;
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
      aw_have = 1'b0;
      w_have  = 1'b0;
      exp_b.delete();
      exp_r.delete();
      checkOutput("rst_awready", S_AXI_AWREADY, 0);
      checkOutput("rst_wready",  S_AXI_WREADY,  0);
      checkOutput("rst_arready", S_AXI_ARREADY, 0);
      checkOutput("rst_bvalid",  S_AXI_BVALID,  0);
      checkOutput("rst_rvalid",  S_AXI_RVALID,  0);
      checkOutput("rst_bresp",   S_AXI_BRESP,   0);
      checkOutput("rst_rresp",   S_AXI_RRESP,   0);
      checkOutput("rst_rdata",   S_AXI_RDATA,   0);
      for (int i = 0; i < 4; i++) checkOutput("rst_reg_out", reg_out[i], 0);
    end else begin
      exp_awr = armed && !aw_have && (exp_b.size() == 0);
      exp_wr  = armed && !w_have  && (exp_b.size() == 0);
      exp_arr = armed && (exp_r.size() == 0);
      checkOutput("awready", S_AXI_AWREADY, exp_awr);
      checkOutput("wready",  S_AXI_WREADY,  exp_wr);
      checkOutput("arready", S_AXI_ARREADY, exp_arr);
      checkOutput("bvalid",  S_AXI_BVALID,  exp_b.size() != 0);
      if (exp_b.size() != 0) checkOutput("bresp", S_AXI_BRESP, exp_b[0]);
      checkOutput("rvalid",  S_AXI_RVALID,  exp_r.size() != 0);
      if (exp_r.size() != 0) begin
        checkOutput("rdata", S_AXI_RDATA, exp_r[0][31:0]);
        checkOutput("rresp", S_AXI_RRESP, exp_r[0][33:32]);
      end
      for (int i = 0; i < 4; i++) checkOutput("reg_out", reg_out[i], model_regs[i]);
      if (exp_b.size() != 0 && S_AXI_BREADY) void'(exp_b.pop_front());
      if (exp_r.size() != 0 && S_AXI_RREADY) void'(exp_r.pop_front());
      if (S_AXI_ARVALID && exp_arr) exp_r.push_back(model_read(S_AXI_ARADDR));
      if (S_AXI_AWVALID && exp_awr) begin
        aw_have   = 1'b1;
        m_aw_addr = S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && exp_wr) begin
        w_have   = 1'b1;
        m_w_data = S_AXI_WDATA;
        m_w_strb = S_AXI_WSTRB;
      end
      if (aw_have && w_have) begin
        model_write(m_aw_addr, m_w_data, m_w_strb);
        aw_have = 1'b0;
        w_have  = 1'b0;
      end
    end
  end

  // One write: W leads AW by w_lead cycles; BREADY withheld for bready_delay cycles.
  task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int w_lead, input int bready_delay,
                               output logic [1:0] resp, output int b_lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    resp  = 2'b11;
    b_lat = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    S_AXI_AWVALID = (w_lead == 0);
    S_AXI_BREADY  = (bready_delay == 0);
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; end
      cyc++;
      if (!aw_done && cyc >= w_lead) S_AXI_AWVALID = 1'b1;
      if (cyc > 50) begin
        checkOutput("aw_w_timeout", 0, 1);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        return;
      end
    end
    while (b_lat < 50) begin
      @(negedge ACLK);
      b_lat++;
      if (S_AXI_BVALID) break;
    end
    if (!S_AXI_BVALID) begin
      checkOutput("b_timeout", 0, 1);
      S_AXI_BREADY = 1'b0;
      return;
    end
    resp = S_AXI_BRESP;
    for (int k = 0; k < bready_delay; k++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      checkOutput("b_hold_valid",   S_AXI_BVALID,  1);
      checkOutput("b_hold_resp",    S_AXI_BRESP,   resp);
      checkOutput("b_hold_awready", S_AXI_AWREADY, 0);
      checkOutput("b_hold_wready",  S_AXI_WREADY,  0);
    end
    if (bready_delay > 0) begin
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  // One read; RREADY withheld for rready_delay cycles once RVALID is up.
  task automatic applyReadStimulus(input logic [5:0] addr, input int rready_delay,
                                   output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int cyc;
    data = 32'hxxxx_xxxx;
    resp = 2'b11;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = (rready_delay == 0);
    hs  = 0;
    cyc = 0;
    while (!hs) begin
      @(negedge ACLK);
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (hs) S_AXI_ARVALID = 1'b0;
      cyc++;
      if (!hs && cyc > 50) begin
        checkOutput("ar_timeout", 0, 1);
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        return;
      end
    end
    cyc = 0;
    while (cyc < 50) begin
      @(negedge ACLK);
      cyc++;
      if (S_AXI_RVALID) break;
    end
    if (!S_AXI_RVALID) begin
      checkOutput("r_timeout", 0, 1);
      S_AXI_RREADY = 1'b0;
      return;
    end
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    for (int k = 0; k < rready_delay; k++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      checkOutput("r_hold_valid",   S_AXI_RVALID,  1);
      checkOutput("r_hold_data",    S_AXI_RDATA,   data);
      checkOutput("r_hold_arready", S_AXI_ARREADY, 0);
    end
    if (rready_delay > 0) begin
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] wvals [4];
    wvals = '{32'h1, 32'h2, 32'h3, 32'h4};

    ARESETN       = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;

    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    checkOutput("ready_before_first_edge", S_AXI_AWREADY, 0);
    @(negedge ACLK);
    checkOutput("awready_after_first_edge", S_AXI_AWREADY, 1);
    checkOutput("arready_after_first_edge", S_AXI_ARREADY, 1);
    @(posedge ACLK); #1;

    $display("[TB] sequential writes and readback");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(6'(i * 4), wvals[i], 4'hF, 0, 0, resp, lat);
      checkOutput("seq_bresp", resp, 2'b00);
      checkOutput("seq_b_latency", lat, 1);
    end
    for (int i = 0; i < 4; i++) begin
      applyReadStimulus(6'(i * 4), 0, rdata, resp);
      checkOutput("seq_rdata", rdata, wvals[i]);
      checkOutput("seq_rresp", resp, 2'b00);
    end

    $display("[TB] W leads AW by three cycles");
    applyStimulus(6'h04, 32'hDEAD_BEEF, 4'hF, 3, 0, resp, lat);
    checkOutput("wlead_bresp", resp, 2'b00);
    checkOutput("wlead_b_latency", lat, 1);
    checkOutput("wlead_reg1", reg_out[1], 32'hDEAD_BEEF);

    $display("[TB] partial strobe");
    applyStimulus(6'h08, 32'h1122_3344, 4'hF, 0, 0, resp, lat);
    applyStimulus(6'h08, 32'hAABB_CCDD, 4'b0010, 0, 0, resp, lat);
    applyReadStimulus(6'h08, 0, rdata, resp);
    checkOutput("strb_rdata", rdata, 32'h1122_CC44);

    $display("[TB] ID and unmapped accesses");
    applyStimulus(6'h10, 32'h0, 4'hF, 0, 0, resp, lat);
    checkOutput("id_write_bresp", resp, 2'b10);
    applyReadStimulus(6'h10, 0, rdata, resp);
    checkOutput("id_rdata", rdata, 32'h7E57_0100);
    checkOutput("id_rresp", resp, 2'b00);
    applyReadStimulus(6'h20, 0, rdata, resp);
    checkOutput("unmapped_rdata", rdata, 32'h0);
    checkOutput("unmapped_rresp", resp, 2'b10);
    applyStimulus(6'h24, 32'h5555_5555, 4'hF, 0, 0, resp, lat);
    checkOutput("unmapped_bresp", resp, 2'b10);
    checkOutput("unmapped_reg1_kept", reg_out[1], 32'hDEAD_BEEF);

    $display("[TB] back-pressure on B and R");
    applyStimulus(6'h0C, 32'h0BAD_F00D, 4'hF, 0, 10, resp, lat);
    checkOutput("bp_bresp", resp, 2'b00);
    applyReadStimulus(6'h0C, 10, rdata, resp);
    checkOutput("bp_rdata", rdata, 32'h0BAD_F00D);

    $display("[TB] read colliding with commit to the same register");
    S_AXI_AWADDR  = 6'h00;
    S_AXI_WDATA   = 32'h0000_0055;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_ARADDR  = 6'h00;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY  = 1'b1;
    S_AXI_RREADY  = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("collide_rdata_old", S_AXI_RDATA, 32'h1);
    checkOutput("collide_reg0_new", reg_out[0], 32'h55);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;

    $display("[TB] reset while only AW is held");
    S_AXI_AWADDR  = 6'h0C;
    S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      checkOutput("post_reset_bvalid", S_AXI_BVALID, 0);
    end
    for (int i = 0; i < 4; i++) checkOutput("post_reset_reg", reg_out[i], 32'h0);
    @(posedge ACLK); #1;
    applyStimulus(6'h0C, 32'hCAFE_F00D, 4'hF, 0, 0, resp, lat);
    checkOutput("post_reset_bresp", resp, 2'b00);
    applyReadStimulus(6'h0C, 0, rdata, resp);
    checkOutput("post_reset_rdata", rdata, 32'hCAFE_F00D);

    repeat (3) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
